// File: rtl/neuron_pkg.sv
// Shared types and elaboration-time helpers for the neuron datapath blocks:
// state encoding, width derivation and saturation bounds.
package neuron_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Wide enough for bias plus TERMS full-scale terms without wrapping.
  function automatic int acc_width(input int din_w, input int b_w, input int terms);
    return max_int(din_w, b_w) + clog2(terms + 1) + 1;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/neuron_acc_sat_sat_clip.sv
// Combinational signed clipper: narrows IN_W to OUT_W, saturating at the
// OUT_W bounds and flagging when clipping happened.
module sat_clip
  import neuron_pkg::*;
#(
  parameter int IN_W  = 25,
  parameter int OUT_W = 22
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             ovf_o
);

  logic signed [IN_W-1:0] in_s;
  assign in_s = $signed(in_i);

  generate
    if (OUT_W >= IN_W) begin : g_pass
      // Output already covers the full input range; only sign extension.
      assign out_o = OUT_W'(in_s);
      assign ovf_o = 1'b0;
    end else begin : g_clip
      localparam logic signed [IN_W-1:0] MAXV = IN_W'(sat_max(OUT_W));
      localparam logic signed [IN_W-1:0] MINV = IN_W'(sat_min(OUT_W));

      always_comb begin
        out_o = in_s[OUT_W-1:0];
        ovf_o = 1'b0;
        if (in_s > MAXV) begin
          out_o = MAXV[OUT_W-1:0];
          ovf_o = 1'b1;
        end else if (in_s < MINV) begin
          out_o = MINV[OUT_W-1:0];
          ovf_o = 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/neuron_acc_sat.sv
// Frame accumulator: bias + TERMS signed terms, saturated to OUT_W and held on
// a valid/ready port. Define NEURON_ACC_RELU_EN to clamp negative results to 0.
module neuron_acc_sat
  import neuron_pkg::*;
#(
  parameter int DIN_W = 20,
  parameter int B_W   = 8,
  parameter int TERMS = 8,
  parameter int OUT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [B_W-1:0]   bias,
  output logic [OUT_W-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int ACC_W = acc_width(DIN_W, B_W, TERMS);
  localparam int CNT_W = clog2(TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMS - 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  acc_base, sum;
  logic signed [OUT_W-1:0]  dout_q, dout_d;
  logic                     ovf_q, ovf_d;
  logic [OUT_W-1:0]         sat_val;
  logic                     sat_ovf;
  logic signed [OUT_W-1:0]  res_val;

`ifdef NEURON_ACC_RELU_EN
  function automatic logic signed [OUT_W-1:0] relu(input logic signed [OUT_W-1:0] v);
    return v[OUT_W-1] ? '0 : v;
  endfunction
  assign res_val = relu($signed(sat_val));
`else
  assign res_val = $signed(sat_val);
`endif

  // The first term of a frame restarts from the bias rather than the old sum.
  assign acc_base = (cnt_q == '0) ? ACC_W'($signed(bias)) : acc_q;
  assign sum      = acc_base + ACC_W'($signed(din));

  sat_clip #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat_clip (
    .in_i  (sum),
    .out_o (sat_val),
    .ovf_o (sat_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = sum;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
            dout_d  = res_val;
            ovf_d   = sat_ovf;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Holding in_ready low during reset keeps upstream from counting a transfer.
  assign in_ready  = rst & (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_neuron_acc_sat.sv
// Bench for neuron_acc_sat: table vectors, hand sequences and random frames
// checked against an arithmetic model; also covers a TERMS=1 instance.
module tb_neuron_acc_sat;

  localparam int DIN_W = 20;
  localparam int B_W   = 8;
  localparam int OUT_W = 22;

  logic clk, rst;
  logic [DIN_W-1:0] din, din1;
  logic [B_W-1:0]   bias, bias1;
  logic             in_valid, in_ready, out_valid, out_ready, ovf;
  logic             in_valid1, in_ready1, out_valid1, out_ready1, ovf1;
  logic [OUT_W-1:0] dout, dout1;

  int n_tests = 0;
  int n_fail  = 0;

  neuron_acc_sat #(.DIN_W(DIN_W), .B_W(B_W), .TERMS(8), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .bias(bias), .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  neuron_acc_sat #(.DIN_W(DIN_W), .B_W(B_W), .TERMS(1), .OUT_W(OUT_W)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .in_valid(in_valid1), .in_ready(in_ready1),
    .bias(bias1), .dout(dout1), .out_valid(out_valid1), .out_ready(out_ready1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    longint b;
    longint t[8];
    int     gap;
    int     stall;
    longint exp_d;
    bit     exp_o;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer sum, clip to the OUT_W range, optional ReLU.
  task automatic ref_sat(input longint s, output longint d, output bit o);
    longint mx, mn;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
    mn = -(longint'(1) <<< (OUT_W - 1));
    o = 1'b0;
    d = s;
    if (s > mx) begin d = mx; o = 1'b1; end
    else if (s < mn) begin d = mn; o = 1'b1; end
`ifdef NEURON_ACC_RELU_EN
    if (d < 0) d = 0;
`endif
  endtask

  task automatic send_frame(input longint b, input longint t[8], input int gap_max);
    int k;
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        din  = DIN_W'($urandom);
        bias = B_W'($urandom);
        step();
      end
      k = 0;
      while (!in_ready && k < 20) begin step(); k++; end
      if (!in_ready) begin
        check("in_ready_timeout", 0, 1);
        return;
      end
      if (i == 7) check("no_early_valid", longint'(out_valid), 0);
      in_valid = 1'b1;
      din  = DIN_W'(t[i]);
      bias = (i == 0) ? B_W'(b) : B_W'($urandom);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input string nm, input longint exp_d, input bit exp_o, input int stall);
    check({nm, "_valid"}, longint'(out_valid), 1);
    check({nm, "_dout"}, $signed(dout), exp_d);
    check({nm, "_ovf"}, longint'(ovf), longint'(exp_o));
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      check({nm, "_hold_dout"}, $signed(dout), exp_d);
      check({nm, "_hold_valid"}, longint'(out_valid), 1);
      check({nm, "_hold_inrdy"}, longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_post_valid"}, longint'(out_valid), 0);
    check({nm, "_post_inrdy"}, longint'(in_ready), 1);
  endtask

  initial begin
    longint d;
    bit o;
    longint s;
    longint t[8];

    // name, bias, terms, max gap, stall, expected dout, expected ovf
    vecs[0] = '{"nominal", 11, '{1, 2, 3, 4, -3, 2, -5, 10}, 0, 0, 25, 0};
    vecs[1] = '{"gaps_stall", 11, '{1, 2, 3, 4, -3, 2, -5, 10}, 3, 5, 25, 0};
    vecs[2] = '{"pos_sat", 127, '{8{524287}}, 0, 1, 2097151, 1};
    vecs[3] = '{"pos_edge", 3, '{524287, 524287, 524287, 524287, 0, 0, 0, 0}, 0, 0, 2097151, 0};
    vecs[4] = '{"pos_edge1", 4, '{524287, 524287, 524287, 524287, 0, 0, 0, 0}, 1, 0, 2097151, 1};
`ifdef NEURON_ACC_RELU_EN
    vecs[5] = '{"neg_sat", -128, '{8{-524288}}, 0, 2, 0, 1};
    vecs[6] = '{"neg_edge", 0, '{-524288, -524288, -524288, -524288, 0, 0, 0, 0}, 0, 0, 0, 0};
`else
    vecs[5] = '{"neg_sat", -128, '{8{-524288}}, 0, 2, -2097152, 1};
    vecs[6] = '{"neg_edge", 0, '{-524288, -524288, -524288, -524288, 0, 0, 0, 0}, 0, 0, -2097152, 0};
`endif

    rst = 1'b0; din = '0; bias = '0; in_valid = 1'b0; out_ready = 1'b0;
    din1 = '0; bias1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    step();
    check("rst_inrdy", longint'(in_ready), 0);
    check("rst_valid", longint'(out_valid), 0);
    check("rst_dout", $signed(dout), 0);
    check("rst_ovf", longint'(ovf), 0);
    check("rst1_inrdy", longint'(in_ready1), 0);
    check("rst1_valid", longint'(out_valid1), 0);
    rst = 1'b1;
    step();
    check("idle_inrdy", longint'(in_ready), 1);

    foreach (vecs[v]) begin
      send_frame(vecs[v].b, vecs[v].t, vecs[v].gap);
      collect(vecs[v].name, vecs[v].exp_d, vecs[v].exp_o, vecs[v].stall);
    end

    // Reset mid-frame: partial sum and bias discarded.
    bias = 8'd11;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      din = DIN_W'(100);
      step();
      bias = B_W'($urandom);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_inrdy", longint'(in_ready), 0);
    step();
    check("midrst_valid", longint'(out_valid), 0);
    rst = 1'b1;
    step();
    t = '{8{1}};
    send_frame(0, t, 0);
    collect("midrst_frame", 8, 0, 0);

    // Reset while a result is pending drops it.
    t = '{1, 2, 3, 4, -3, 2, -5, 10};
    send_frame(11, t, 0);
    check("donerst_pre", longint'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("donerst_valid", longint'(out_valid), 0);
    step();
    rst = 1'b1;
    step();
    check("donerst_after", longint'(out_valid), 0);
    check("donerst_inrdy", longint'(in_ready), 1);

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      logic signed [B_W-1:0] rb;
      rb = B_W'($urandom);
      s = longint'(rb);
      for (int i = 0; i < 8; i++) begin
        logic signed [DIN_W-1:0] rt;
        if ($urandom_range(0, 2) == 0) rt = DIN_W'($urandom);
        else rt = DIN_W'(int'($urandom_range(0, 2000)) - 1000);
        if (f % 5 == 4) rt = (f % 10 == 4) ? 20'sh7FFFF : 20'sh80000;
        t[i] = longint'(rt);
        s += t[i];
      end
      ref_sat(s, d, o);
      send_frame(longint'(rb), t, 2);
      collect("rand", d, o, int'($urandom_range(0, 3)));
    end

    // TERMS=1: each accepted term completes a frame.
    out_ready1 = 1'b1;
    check("t1_inrdy0", longint'(in_ready1), 1);
    bias1 = B_W'(-2);
    din1 = DIN_W'(5);
    in_valid1 = 1'b1;
    step();
    ref_sat(3, d, o);
    check("t1_valid_a", longint'(out_valid1), 1);
    check("t1_dout_a", $signed(dout1), d);
    check("t1_ovf_a", longint'(ovf1), longint'(o));
    check("t1_bubble", longint'(in_ready1), 0);
    bias1 = B_W'(3);
    din1 = DIN_W'(-7);
    step();
    check("t1_gap_valid", longint'(out_valid1), 0);
    check("t1_gap_inrdy", longint'(in_ready1), 1);
    step();
    in_valid1 = 1'b0;
    ref_sat(-4, d, o);
    check("t1_valid_b", longint'(out_valid1), 1);
    check("t1_dout_b", $signed(dout1), d);
    step();
    check("t1_done", longint'(out_valid1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
